ame_equation_accum: RTL and testbench
=====================================

Name: ame_equation_accum

Overview:
- Upstream feeder of the affine motion-estimation equation solver.
- Consumes a stream of per-sample gradient coefficient vectors c[5:0] and residuals d.
- Accumulates the normal-equation system A[i][j] = sum c[i]*c[j] and B[i] = sum c[i]*d, and presents it as a 6 x 7 integer matrix (column 6 = B) with a one-cycle done pulse, ready to launch the solver.

Parameters:
- COEF_BITS, 16, signed width of each coefficient c[i].
- DIFF_BITS, 12, signed width of residual d.
- COMP_DATA_BITS, 64, signed width of each accumulated matrix entry.
- CNT_BITS, 12, width of the accepted-sample counter.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- comp_init_i  input  1  clear all accumulators and start a new block; also selects the mode.
- affine_param6_i  input  1  1 = 6-parameter model, 0 = 4-parameter model; sampled on comp_init_i.
- samp_valid_i  input  1  sample valid.
- samp_ready_o  output  1  sample accepted when valid & ready.
- samp_last_i  input  1  marks the final sample of the block; qualified by valid & ready.
- samp_coef_i  input  6 x COEF_BITS  signed coefficients c[5:0].
- samp_diff_i  input  DIFF_BITS  signed residual d.
- comp_done_o  output  1  one-cycle pulse: matrix complete.
- comp_data_o  output  6 x 7 x COMP_DATA_BITS  accumulated matrix [row][col]; col 6 = B.
- samp_count_o  output  CNT_BITS  samples accepted in the current block; saturates at all-ones.

Behaviour:
- Reset values: comp_done_o=0, samp_ready_o=0, comp_data_o=0, samp_count_o=0, state IDLE, mode latch=6-param.
- State IDLE -> ACCUM when comp_init_i=1.
  - On entry: all accumulators and the counter clear to 0; the mode is latched.
- ACCUM:
  - samp_ready_o=1.
  - Each valid & ready sample enters a 2-stage pipeline:
    - stage 1 registers the 27 products: 21 upper-triangle c[i]*c[j] for i<=j, plus 6 c[i]*d;
    - stage 2 adds the sign-extended products into the accumulators.
  - An accepted sample with samp_last_i=1 -> DRAIN.
- DRAIN:
  - samp_ready_o=0.
  - Waits exactly 2 cycles for the pipeline to empty, then -> DONE.
- DONE:
  - comp_done_o=1 for exactly one cycle, then -> IDLE.
  - comp_data_o reflects the final sums from the cycle comp_done_o is high.
  - comp_data_o is held stable until the next comp_init_i.
- Latency: comp_done_o asserts 3 cycles after the clock edge that accepts the last sample.
- Symmetry: only the upper triangle is stored; comp_data_o[j][i] is driven from comp_data_o[i][j] for j>i.
- 4-parameter mode:
  - rows 0..1 and cols 0..1 of A and B[0..1] are held at 0;
  - c[0], c[1] are ignored; only rows/cols 2..5 accumulate.
- Arithmetic:
  - products are full-precision signed (2*COEF_BITS, COEF_BITS+DIFF_BITS);
  - products are sign-extended to COMP_DATA_BITS;
  - addition wraps modulo 2^COMP_DATA_BITS (default build).
- comp_init_i asserted in any state (including ACCUM or DRAIN mid-block):
  - aborts the block: pipeline contents are discarded, accumulators are cleared, no comp_done_o;
  - re-enters ACCUM next cycle.
  - If it coincides with the DONE cycle, the done pulse still fires and the clear takes effect next cycle.
- Samples offered while samp_ready_o=0 are not accepted and do not affect any state.
- The counter increments per accepted sample and saturates; it does not wrap.
- Async reset mid-block: everything returns to reset values immediately.

Optional Feature:
- Macro: AME_ACCUM_SATURATE_EN.
- Defined: each accumulator addition saturates to [-(2^(COMP_DATA_BITS-1)), 2^(COMP_DATA_BITS-1)-1] on signed overflow instead of wrapping.
- Not defined: modulo-2^COMP_DATA_BITS wrap.
- Ports and latency are identical in both builds.

Test Plan:
- 6-param, single sample c={1,2,3,4,5,6}, d=2, last=1 -> comp_done_o 3 cycles after accept; A[i][j]=c[i]*c[j] (A[5][5]=36, A[0][5]=A[5][0]=6); B={2,4,6,8,10,12}; samp_count_o=1.
- 4-param, 3 samples c={9,9,1,-1,2,-2}, d=-3 -> A[2][2]=3, A[3][5]=6, A[2][3]=-3; B[2]=-9; rows/cols 0,1 all 0; count=3.
- Back-pressure: valid toggles 1,0,1,1 with last on the 4th cycle and c all 1, d=1 -> 3 samples accepted; every A=3 and B=3.
- Abort: comp_init_i re-asserted 1 cycle after accepting 5 samples, then 1 sample c all 2, d=1 -> A all 4, B all 2, count=1; only one comp_done_o.
- Extremes: 1000 samples c all -32768, d=-2048 -> A[i][j]=1000*2^30, B[i]=1000*2^26; no overflow.
- Overflow: COMP_DATA_BITS=32 with c all -32768 for 3 samples -> A = 3*2^30 wraps to -2^30 in the default build; with AME_ACCUM_SATURATE_EN, A = 2^31-1.

Source files
------------

// File: rtl/ame_equation_accum.sv
// ame_equation_accum: accumulates the 6x7 normal-equation system
//   A[i][j] = sum c[i]*c[j], B[i] = sum c[i]*d
// for the affine motion-estimation solver. Two-stage datapath:
// stage 1 registers the 27 products, stage 2 adds them into the accumulators.
// Only the upper triangle of A is stored; the lower triangle is mirrored.
// Optional build macro: AME_ACCUM_SATURATE_EN (saturating accumulation
// instead of modulo wrap).
module ame_equation_accum #(
    parameter int unsigned COEF_BITS      = 16,
    parameter int unsigned DIFF_BITS      = 12,
    parameter int unsigned COMP_DATA_BITS = 64,
    parameter int unsigned CNT_BITS       = 12
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  comp_init_i,
    input  logic                                  affine_param6_i,
    input  logic                                  samp_valid_i,
    output logic                                  samp_ready_o,
    input  logic                                  samp_last_i,
    input  logic [5:0][COEF_BITS-1:0]             samp_coef_i,
    input  logic [DIFF_BITS-1:0]                  samp_diff_i,
    output logic                                  comp_done_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]   comp_data_o,
    output logic [CNT_BITS-1:0]                   samp_count_o
);

    localparam int unsigned N_COEF = 6;
    localparam int unsigned N_TRI  = 21;
    localparam int unsigned PCC_W  = 2 * COEF_BITS;
    localparam int unsigned PCD_W  = COEF_BITS + DIFF_BITS;
    localparam int unsigned IDX6_W = 3;
    localparam int unsigned TRI_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [1:0]                     r_drain_cnt;
    logic                           r_mode6;
    logic                           r_ready;
    logic                           r_done;
    logic                           r_p_valid;
    logic                           w_accept;
    logic signed [COEF_BITS-1:0]    w_coef [N_COEF];
    logic signed [DIFF_BITS-1:0]    w_diff;
    logic signed [PCC_W-1:0]        r_prod_cc [N_TRI];
    logic signed [PCD_W-1:0]        r_prod_cd [N_COEF];
    logic [COMP_DATA_BITS-1:0]      r_acc_a [N_TRI];
    logic [COMP_DATA_BITS-1:0]      r_acc_b [N_COEF];
    logic [CNT_BITS-1:0]            r_count;

    // Flat index of upper-triangle entry (i,j), i <= j, row-major.
    function automatic logic [TRI_W-1:0] tri_idx(input int i, input int j);
        return TRI_W'((i * (2 * N_COEF - i + 1)) / 2 + (j - i));
    endfunction

    // Accumulator add: modulo wrap, or clamp on signed overflow when enabled.
    function automatic logic [COMP_DATA_BITS-1:0] acc_add(
        input logic [COMP_DATA_BITS-1:0] a,
        input logic [COMP_DATA_BITS-1:0] b
    );
        logic [COMP_DATA_BITS-1:0] s;
        s = a + b;
`ifdef AME_ACCUM_SATURATE_EN
        if ((a[COMP_DATA_BITS-1] == b[COMP_DATA_BITS-1]) &&
            (s[COMP_DATA_BITS-1] != a[COMP_DATA_BITS-1])) begin
            s = a[COMP_DATA_BITS-1] ? {1'b1, {(COMP_DATA_BITS-1){1'b0}}}
                                    : {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    // A sample is taken only while accumulating; a concurrent init discards it.
    assign w_accept = samp_valid_i & r_ready & ~comp_init_i;

    // Input conditioning: in 4-parameter mode c[0], c[1] are forced to zero.
    always_comb begin
        w_diff = $signed(samp_diff_i);
        for (int i = 0; i < int'(N_COEF); i++) begin
            w_coef[IDX6_W'(i)] = ((i < 2) && !r_mode6) ? '0 : $signed(samp_coef_i[IDX6_W'(i)]);
        end
    end

    // Next-state logic; init from any state restarts accumulation.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_ACCUM: if (w_accept && samp_last_i) w_state_nxt = S_DRAIN;
            // Drain covers both pipeline stages plus one cycle so that done
            // lands three edges after the edge that accepted the last sample.
            S_DRAIN: if (r_drain_cnt == 2'd2) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (comp_init_i) begin
            w_state_nxt = S_ACCUM;
        end
    end

    // State register, drain counter, registered handshake/done and mode latch.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 2'd0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_mode6     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= ((r_state == S_DRAIN) && (w_state_nxt == S_DRAIN))
                           ? r_drain_cnt + 2'd1 : 2'd0;
            r_ready     <= (w_state_nxt == S_ACCUM);
            r_done      <= (w_state_nxt == S_DONE);
            if (comp_init_i) begin
                r_mode6 <= affine_param6_i;
            end
        end
    end

    // Stage 1: register full-precision products of the accepted sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_p_valid <= 1'b0;
            for (int k = 0; k < int'(N_TRI); k++)  r_prod_cc[TRI_W'(k)]  <= '0;
            for (int k = 0; k < int'(N_COEF); k++) r_prod_cd[IDX6_W'(k)] <= '0;
        end else begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < int'(N_COEF); i++) begin
                    for (int j = i; j < int'(N_COEF); j++) begin
                        r_prod_cc[tri_idx(i, j)] <= PCC_W'(w_coef[IDX6_W'(i)]) *
                                                    PCC_W'(w_coef[IDX6_W'(j)]);
                    end
                    r_prod_cd[IDX6_W'(i)] <= PCD_W'(w_coef[IDX6_W'(i)]) * PCD_W'(w_diff);
                end
            end
        end
    end

    // Stage 2: sign-extend and accumulate; init clears and drops in-flight products.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < int'(N_TRI); k++)  r_acc_a[TRI_W'(k)]  <= '0;
            for (int k = 0; k < int'(N_COEF); k++) r_acc_b[IDX6_W'(k)] <= '0;
        end else if (comp_init_i) begin
            for (int k = 0; k < int'(N_TRI); k++)  r_acc_a[TRI_W'(k)]  <= '0;
            for (int k = 0; k < int'(N_COEF); k++) r_acc_b[IDX6_W'(k)] <= '0;
        end else if (r_p_valid) begin
            for (int k = 0; k < int'(N_TRI); k++) begin
                r_acc_a[TRI_W'(k)] <= acc_add(r_acc_a[TRI_W'(k)],
                                              COMP_DATA_BITS'(r_prod_cc[TRI_W'(k)]));
            end
            for (int k = 0; k < int'(N_COEF); k++) begin
                r_acc_b[IDX6_W'(k)] <= acc_add(r_acc_b[IDX6_W'(k)],
                                               COMP_DATA_BITS'(r_prod_cd[IDX6_W'(k)]));
            end
        end
    end

    // Saturating count of accepted samples in the current block.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
        end else if (comp_init_i) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_BITS{1'b1}})) begin
            r_count <= r_count + CNT_BITS'(1);
        end
    end

    // Matrix view: upper triangle stored, lower triangle mirrored, column 6 = B.
    always_comb begin
        comp_data_o = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (c == 6) begin
                    comp_data_o[IDX6_W'(r)][IDX6_W'(c)] = r_acc_b[IDX6_W'(r)];
                end else if (c >= r) begin
                    comp_data_o[IDX6_W'(r)][IDX6_W'(c)] = r_acc_a[tri_idx(r, c)];
                end else begin
                    comp_data_o[IDX6_W'(r)][IDX6_W'(c)] = r_acc_a[tri_idx(c, r)];
                end
            end
        end
    end

    assign samp_ready_o = r_ready;
    assign comp_done_o  = r_done;
    assign samp_count_o = r_count;

endmodule

// File: tb/tb_ame_equation_accum.sv
// Bench for ame_equation_accum: randomized and directed blocks checked against
// a running-sum model of the normal equations (plain 64-bit arithmetic).
module tb_ame_equation_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    init;
    logic                    mode6;
    logic                    valid;
    logic                    last;
    logic [5:0][15:0]        coef;
    logic [11:0]             diff;
    logic                    ready, done, ready32, done32;
    logic [5:0][6:0][63:0]   data;
    logic [5:0][6:0][31:0]   data32;
    logic [11:0]             count, count32;

    ame_equation_accum dut (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .affine_param6_i(mode6),
        .samp_valid_i(valid), .samp_ready_o(ready), .samp_last_i(last),
        .samp_coef_i(coef), .samp_diff_i(diff), .comp_done_o(done),
        .comp_data_o(data), .samp_count_o(count)
    );

    ame_equation_accum #(.COMP_DATA_BITS(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .affine_param6_i(mode6),
        .samp_valid_i(valid), .samp_ready_o(ready32), .samp_last_i(last),
        .samp_coef_i(coef), .samp_diff_i(diff), .comp_done_o(done32),
        .comp_data_o(data32), .samp_count_o(count32)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint m_a [6][6];
    longint m_b [6];
    int     m_cnt;
    bit     m_mode6;
    bit     exp_ready;

    // Model: start an empty system.
    task automatic model_clear(input bit m6);
        m_mode6 = m6;
        m_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            m_b[i] = 0;
            for (int j = 0; j < 6; j++) m_a[i][j] = 0;
        end
    endtask

    // Model: fold one accepted sample into the normal equations.
    task automatic model_accept(input int c[6], input int d);
        longint e [6];
        for (int i = 0; i < 6; i++) e[i] = (!m_mode6 && i < 2) ? 0 : longint'(c[i]);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) m_a[i][j] += e[i] * e[j];
            m_b[i] += e[i] * longint'(d);
        end
        if (m_cnt < 4095) m_cnt++;
    endtask

    task automatic start_block(input bit m6);
        init  = 1'b1;
        mode6 = m6;
        valid = 1'b0;
        last  = 1'b0;
        @(negedge clk);
        init = 1'b0;
        model_clear(m6);
        exp_ready = 1'b1;
    endtask

    // One clock of sample offer; acceptance follows the model's notion of ready.
    task automatic drive_cycle(input bit v, input int c[6], input int d, input bit l);
        n_vec++;
        if (ready !== exp_ready) begin
            n_err++;
            $display("FAIL ready: got %b expected %b at %0t", ready, exp_ready, $time);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL unexpected_done: got %b expected 0 at %0t", done, $time);
        end
        valid = v;
        last  = l;
        for (int i = 0; i < 6; i++) coef[i] = 16'(c[i]);
        diff = 12'(d);
        @(negedge clk);
        if (v && exp_ready) begin
            model_accept(c, d);
            if (l) exp_ready = 1'b0;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // After the accepting edge: done must pulse on exactly the third edge,
    // with the final matrix and count visible in that cycle.
    task automatic wait_done(input string name);
        bit exp_d;
        valid = 1'b0;
        last  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_d = (k == 3);
            n_vec++;
            if (done !== exp_d) begin
                n_err++;
                $display("FAIL %s done_latency: edge %0d got %b expected %b", name, k, done, exp_d);
            end
            if (k == 3) begin
                for (int r = 0; r < 6; r++) begin
                    for (int c = 0; c < 7; c++) begin
                        longint e, g;
                        e = (c == 6) ? m_b[r] : m_a[r][c];
                        g = $signed(data[r][c]);
                        n_vec++;
                        if (g !== e) begin
                            n_err++;
                            $display("FAIL %s data[%0d][%0d]: got %0d expected %0d", name, r, c, g, e);
                        end
                    end
                end
                n_vec++;
                if (count !== 12'(m_cnt)) begin
                    n_err++;
                    $display("FAIL %s count: got %0d expected %0d", name, count, m_cnt);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; mode6 = 1'b1; valid = 1'b0; last = 1'b0;
        coef = '0; diff = '0;
        model_clear(1'b1);
        exp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (ready !== 1'b0 || done !== 1'b0 || count !== 12'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready %b done %b count %0d expected 0 0 0", ready, done, count);
        end
        n_vec++;
        if (data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got nonzero matrix expected all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_6param();
        int c [6] = '{1, 2, 3, 4, 5, 6};
        start_block(1'b1);
        drive_cycle(1'b1, c, 2, 1'b1);
        wait_done("single6");
        n_vec++;
        if ($signed(data[5][5]) !== 64'sd36 || $signed(data[0][5]) !== 64'sd6 ||
            $signed(data[5][0]) !== 64'sd6 || $signed(data[5][6]) !== 64'sd12 || count !== 12'd1) begin
            n_err++;
            $display("FAIL single6_const: A55 %0d A05 %0d A50 %0d B5 %0d cnt %0d expected 36 6 6 12 1",
                     $signed(data[5][5]), $signed(data[0][5]), $signed(data[5][0]), $signed(data[5][6]), count);
        end
    endtask

    task automatic test_4param();
        int c [6] = '{9, 9, 1, -1, 2, -2};
        start_block(1'b0);
        for (int s = 0; s < 3; s++) drive_cycle(1'b1, c, -3, s == 2);
        wait_done("param4");
        n_vec++;
        if ($signed(data[2][2]) !== 64'sd3 || $signed(data[3][5]) !== 64'sd6 ||
            $signed(data[2][3]) !== -64'sd3 || $signed(data[2][6]) !== -64'sd9 ||
            data[0][0] !== 64'd0 || data[1][6] !== 64'd0 || count !== 12'd3) begin
            n_err++;
            $display("FAIL param4_const: A22 %0d A35 %0d A23 %0d B2 %0d A00 %0d B1 %0d cnt %0d expected 3 6 -3 -9 0 0 3",
                     $signed(data[2][2]), $signed(data[3][5]), $signed(data[2][3]), $signed(data[2][6]),
                     $signed(data[0][0]), $signed(data[1][6]), count);
        end
    endtask

    task automatic test_backpressure();
        int c [6] = '{1, 1, 1, 1, 1, 1};
        bit v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        start_block(1'b1);
        for (int s = 0; s < 4; s++) drive_cycle(v[s], c, 1, s == 3);
        wait_done("backpressure");
        n_vec++;
        if ($signed(data[0][0]) !== 64'sd3 || $signed(data[4][1]) !== 64'sd3 ||
            $signed(data[3][6]) !== 64'sd3 || count !== 12'd3) begin
            n_err++;
            $display("FAIL backpressure_const: A00 %0d A41 %0d B3 %0d cnt %0d expected 3 3 3 3",
                     $signed(data[0][0]), $signed(data[4][1]), $signed(data[3][6]), count);
        end
        // Samples offered while idle must leave the held result untouched.
        for (int s = 0; s < 4; s++) drive_cycle(1'b1, c, 5, s == 3);
        n_vec++;
        if ($signed(data[0][0]) !== 64'sd3 || $signed(data[2][6]) !== 64'sd3 || count !== 12'd3) begin
            n_err++;
            $display("FAIL idle_hold: A00 %0d B2 %0d cnt %0d expected 3 3 3",
                     $signed(data[0][0]), $signed(data[2][6]), count);
        end
    endtask

    task automatic test_abort();
        int c [6];
        int c2 [6] = '{2, 2, 2, 2, 2, 2};
        start_block(1'b1);
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 6; i++) c[i] = $urandom_range(1, 100);
            drive_cycle(1'b1, c, 7, 1'b0);
        end
        start_block(1'b1);
        drive_cycle(1'b1, c2, 1, 1'b1);
        wait_done("abort");
        n_vec++;
        if ($signed(data[1][3]) !== 64'sd4 || $signed(data[4][6]) !== 64'sd2 || count !== 12'd1) begin
            n_err++;
            $display("FAIL abort_const: A13 %0d B4 %0d cnt %0d expected 4 2 1",
                     $signed(data[1][3]), $signed(data[4][6]), count);
        end
    endtask

    task automatic test_random();
        int c [6];
        int d, len, acc;
        bit v, m6;
        for (int b = 0; b < 8; b++) begin
            m6  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            acc = 0;
            start_block(m6);
            while (acc < len) begin
                v = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 6; i++) c[i] = int'($signed(16'($urandom)));
                d = int'($signed(12'($urandom)));
                drive_cycle(v, c, d, v && (acc == len - 1));
                if (v) acc++;
            end
            wait_done($sformatf("random%0d", b));
        end
    endtask

    task automatic test_extremes();
        int c [6] = '{-32768, -32768, -32768, -32768, -32768, -32768};
        start_block(1'b1);
        for (int s = 0; s < 1000; s++) drive_cycle(1'b1, c, -2048, s == 999);
        wait_done("extremes");
        n_vec++;
        if ($signed(data[2][4]) !== 64'sd1073741824000 || $signed(data[1][6]) !== 64'sd67108864000) begin
            n_err++;
            $display("FAIL extremes_const: A24 %0d B1 %0d expected 1073741824000 67108864000",
                     $signed(data[2][4]), $signed(data[1][6]));
        end
    endtask

    task automatic test_overflow();
        int c [6] = '{-32768, -32768, -32768, -32768, -32768, -32768};
        int exp_a;
        start_block(1'b1);
        for (int s = 0; s < 3; s++) drive_cycle(1'b1, c, -2048, s == 2);
        wait_done("overflow64");
`ifdef AME_ACCUM_SATURATE_EN
        exp_a = 2147483647;
`else
        exp_a = -1073741824;
`endif
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 7; k++) begin
                int e, g;
                e = (k == 6) ? 201326592 : exp_a;
                g = $signed(data32[r][k]);
                n_vec++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL overflow32 data[%0d][%0d]: got %0d expected %0d", r, k, g, e);
                end
            end
        end
    endtask

    task automatic test_count_saturate();
        int c [6] = '{0, 0, 0, 0, 0, 0};
        start_block(1'b1);
        for (int s = 0; s < 4100; s++) drive_cycle(1'b1, c, 0, s == 4099);
        wait_done("count_sat");
        n_vec++;
        if (count !== 12'hFFF) begin
            n_err++;
            $display("FAIL count_sat_const: got %0d expected 4095", count);
        end
    endtask

    task automatic test_async_reset();
        int c [6] = '{3, 4, 5, 6, 7, 8};
        start_block(1'b1);
        for (int s = 0; s < 3; s++) drive_cycle(1'b1, c, 9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (data !== '0 || ready !== 1'b0 || done !== 1'b0 || count !== 12'd0) begin
            n_err++;
            $display("FAIL async_reset: ready %b done %b count %0d A00 %0d expected 0 0 0 0",
                     ready, done, count, $signed(data[0][0]));
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1'b1);
        exp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_6param();
        test_4param();
        test_backpressure();
        test_abort();
        test_random();
        test_extremes();
        test_overflow();
        test_count_saturate();
        test_async_reset();
        test_single_6param();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
